multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Moore/Mealy control FSM for the multicycle MIPS datapath: one shared memory, one ALU, IR/MDR/A/B/ALUOut regs.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives all datapath enables and muxes.
//  Stalls on a memory ready handshake and counts retired instructions.
//  Sits between the IR opcode field and the datapath; replaces the single-cycle decoder.
// PARAMETERS
//  CNT_WIDTH  32  width of retired-instruction counter (wraps)
// PORTS
//  clk           in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  OP            in   6   opcode, IR[31:26]; valid from DECODE onward
//  mem_ready     in   1   memory completes the current access this cycle
//  PCWrite       out  1   unconditional PC load
//  PCWriteCondEQ out  1   PC load if ALU Zero (BEQ)
//  PCWriteCondNE out  1   PC load if !Zero (BNE)
//  IorD          out  1   mem addr: 0=PC, 1=ALUOut
//  MemRead       out  1   memory read request
//  MemWrite      out  1   memory write request
//  IRWrite       out  1   load IR from mem data
//  MemtoReg      out  2   RF wdata: 00=ALUOut 01=MDR 10=PC
//  RegDst        out  2   RF waddr: 00=rt 01=rd 10=$31
//  RegWrite      out  1   RF write enable
//  ALUSrcA       out  1   0=PC 1=A
//  ALUSrcB       out  2   00=B 01=4 10=ext(imm) 11=sext(imm)<<2
//  ZeroExt       out  1   ext(imm) is zero-extend (ORI/ANDI), else sign
//  ALUOp         out  3   000 ADD 001 SUB 010 LUI 100 ADDI 101 OR 110 AND 111 funct
//  PCSource      out  2   00=ALU 01=ALUOut 10=jump target
//  instr_done    out  1   pulse: last cycle of an instruction
//  illegal_op    out  1   pulse: unsupported OP seen in DECODE
//  retired_cnt   out  CNT_WIDTH  instructions completed
// BEHAVIOUR
//  - reset low: state=S_RESET, retired_cnt=0, every output 0. First edge after release -> FETCH.
//  - Controls are decoded from state; the exceptions are IRWrite, PCWrite and instr_done in memory states,
//    which are gated by mem_ready.
//  - FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
//    Holds while !mem_ready. IRWrite=PCWrite=mem_ready. Goes to DECODE on mem_ready.
//  - DECODE: ALUSrcB=11, ALUOp=ADD (branch target -> ALUOut). Next state by OP:
//    0x00->R_EXEC; 0x08/0x0d/0x0c/0x0f->I_EXEC; 0x23/0x2b->MEM_ADDR;
//    0x04/0x05->BRANCH; 0x02->JUMP; 0x03->JAL.
//    Any other OP: illegal_op=1 and instr_done=1 for one cycle, next FETCH.
//  - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=111 -> R_WB (RegDst=01, MemtoReg=00, RegWrite, done).
//  - I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp ADDI/OR/AND/LUI per OP, ZeroExt for ORI/ANDI.
//    Next I_WB (RegDst=00, RegWrite, done).
//  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD -> MEM_READ (LW) | MEM_WRITE (SW).
//  - MEM_READ: MemRead, IorD=1; hold until mem_ready -> MEM_WB (MemtoReg=01, RegDst=00, RegWrite, done).
//  - MEM_WRITE: MemWrite, IorD=1; hold until mem_ready; instr_done=mem_ready. Next FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01, PCWriteCondEQ (BEQ) or PCWriteCondNE (BNE). Done.
//  - JUMP: PCWrite, PCSource=10, done.
//  - JAL: JUMP controls plus RegWrite, RegDst=10, MemtoReg=10. PC already holds PC+4, so $31 gets the return address.
//  - Latency at zero wait (mem_ready=1): BR/J/JAL 3, R/I/SW 4, LW 5 cycles. Each wait cycle adds 1.
//  - Every terminal state returns to FETCH.
//  - retired_cnt +1 on each instr_done, including illegal ops; wraps at 2^CNT_WIDTH-1 -> 0.
//  - MemRead and MemWrite are never both 1.
//  - Requests stay asserted and stable while waiting.
//  - reset mid-instruction: immediate S_RESET and all outputs 0. No partial write is completed.
//  - Unreachable state encodings: outputs 0, next state FETCH.
// STRUCTURE
//  - mips_ctrl_pkg holds: opcode constants, state encodings (4-bit), ALUOp codes, MemtoReg/RegDst/ALUSrcB/PCSource codes.
//  - Sub-module ctrl_word_decode: combinational state+OP+mem_ready -> control word.
//  - Top holds the state register, next-state logic and retired_cnt.
// TESTING
//  - Hold reset low 3 cycles, release: all outputs 0 during reset; cycle 1 FETCH, MemRead=1, IRWrite=PCWrite=1.
//  - Zero-wait R-type (OP=0x00): 4 cycles, RegWrite=1 only in cycle 4 with RegDst=01; retired_cnt 0->1.
//  - LW with mem_ready low 2 cycles in MEM_READ: 7 cycles total.
//    MemRead and IorD=1 held stable; RegWrite with MemtoReg=01 in the last cycle.
//  - BEQ then BNE: PCWriteCondEQ=1 / PCWriteCondNE=1 in cycle 3 only; ALUOp=001; PCSource=01.
//  - JAL: cycle 3 PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. OP=0x3f: illegal_op pulse in DECODE, next FETCH.
//  - Assert reset during a SW MEM_WRITE wait: MemWrite drops immediately; restart from FETCH.
//    With CNT_WIDTH=4, 16 retirements wrap retired_cnt to 0.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// Pure definitions, no logic or latency of its own.
// No flow control; consumed by the decoder, the interface users and the top.
package multicycle_control_fsm_pkg;

  // Opcodes (IR[31:26]) understood by the controller
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Controller states; encodings 14 and 15 are unreachable
  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_R_WB      = 4'd4,
    S_I_EXEC    = 4'd5,
    S_I_WB      = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_READ  = 4'd8,
    S_MEM_WB    = 4'd9,
    S_MEM_WRITE = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_JAL       = 4'd13
  } state_e;

  // ALU operation select
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_LUI   = 3'b010;
  localparam logic [2:0] ALU_ADDI  = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_AND   = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  // Register-file write data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // Register-file write address select
  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;
  localparam logic [1:0] RDST_R31 = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // PC source select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // Complete datapath control word
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond_eq;
    logic       pc_write_cond_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // True for every opcode the DECODE state can dispatch
  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
      OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: op_is_legal = 1'b1;
      default:                               op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle controller and the MIPS datapath/memory.
// Wires only, no latency.
// mem_ready is the only handshake: the memory stretches an access by holding it low.
interface multicycle_control_fsm_if;
  logic [5:0] OP;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCondEQ;
  logic       PCWriteCondNE;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] MemtoReg;
  logic [1:0] RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ZeroExt;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal_op;

  // Controller side
  modport master (
    input  OP, mem_ready,
    output PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
           IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ZeroExt,
           ALUOp, PCSource, instr_done, illegal_op
  );

  // Datapath / memory side
  modport slave (
    output OP, mem_ready,
    input  PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
           IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ZeroExt,
           ALUOp, PCSource, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control_fsm_ctrl_word_decode.sv
// Maps controller state, opcode and mem_ready to the full datapath control word.
// Purely combinational, zero latency.
// Only IRWrite, PCWrite and instr_done in memory states follow mem_ready; all else is state-decoded.
module ctrl_word_decode
  import multicycle_control_fsm_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  // Control word per state; reset and unreachable encodings leave everything at 0
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCS_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut
        ctrl_o.alu_src_b = SRCB_BRANCH;
        ctrl_o.alu_op    = ALU_ADD;
        if (!op_is_legal(op_i)) begin
          ctrl_o.illegal_op = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_dst    = RDST_RD;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        case (op_i)
          OP_ORI:  begin ctrl_o.alu_op = ALU_OR;  ctrl_o.zero_ext = 1'b1; end
          OP_ANDI: begin ctrl_o.alu_op = ALU_AND; ctrl_o.zero_ext = 1'b1; end
          OP_LUI:  ctrl_o.alu_op = ALU_LUI;
          default: ctrl_o.alu_op = ALU_ADDI;
        endcase
      end
      S_I_WB: begin
        ctrl_o.reg_dst    = RDST_RT;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.mem_to_reg = M2R_MDR;
        ctrl_o.reg_dst    = RDST_RT;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a        = 1'b1;
        ctrl_o.alu_src_b        = SRCB_B;
        ctrl_o.alu_op           = ALU_SUB;
        ctrl_o.pc_source        = PCS_ALUOUT;
        ctrl_o.pc_write_cond_eq = (op_i == OP_BEQ);
        ctrl_o.pc_write_cond_ne = (op_i == OP_BNE);
        ctrl_o.instr_done       = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCS_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCS_JUMP;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = RDST_R31;
        ctrl_o.mem_to_reg = M2R_PC;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS controller: state register, next-state logic and retired-instruction counter.
// Controls valid in the same cycle as the state; BR/J/JAL 3, R/I/SW 4, LW 5 cycles at zero wait.
// FETCH, MEM_READ and MEM_WRITE hold with requests stable while mem_ready is low.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_fsm_if.master bus,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] retired_cnt_q;
  ctrl_t                ctrl;

  ctrl_word_decode u_decode (
    .state_i     (state_q),
    .op_i        (bus.OP),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus.PCWrite       = ctrl.pc_write;
  assign bus.PCWriteCondEQ = ctrl.pc_write_cond_eq;
  assign bus.PCWriteCondNE = ctrl.pc_write_cond_ne;
  assign bus.IorD          = ctrl.i_or_d;
  assign bus.MemRead       = ctrl.mem_read;
  assign bus.MemWrite      = ctrl.mem_write;
  assign bus.IRWrite       = ctrl.ir_write;
  assign bus.MemtoReg      = ctrl.mem_to_reg;
  assign bus.RegDst        = ctrl.reg_dst;
  assign bus.RegWrite      = ctrl.reg_write;
  assign bus.ALUSrcA       = ctrl.alu_src_a;
  assign bus.ALUSrcB       = ctrl.alu_src_b;
  assign bus.ZeroExt       = ctrl.zero_ext;
  assign bus.ALUOp         = ctrl.alu_op;
  assign bus.PCSource      = ctrl.pc_source;
  assign bus.instr_done    = ctrl.instr_done;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign retired_cnt       = retired_cnt_q;

  // Instruction sequencing; every terminal state and any stray encoding returns to FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
    end else begin
      case (state_q)
        S_FETCH:     if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (bus.OP)
            OP_RTYPE:                         state_q <= S_R_EXEC;
            OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_q <= S_I_EXEC;
            OP_LW, OP_SW:                     state_q <= S_MEM_ADDR;
            OP_BEQ, OP_BNE:                   state_q <= S_BRANCH;
            OP_J:                             state_q <= S_JUMP;
            OP_JAL:                           state_q <= S_JAL;
            default:                          state_q <= S_FETCH;
          endcase
        end
        S_R_EXEC:    state_q <= S_R_WB;
        S_I_EXEC:    state_q <= S_I_WB;
        S_MEM_ADDR:  state_q <= (bus.OP == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (bus.mem_ready) state_q <= S_MEM_WB;
        S_MEM_WRITE: if (bus.mem_ready) state_q <= S_FETCH;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  // Count every completed instruction, illegal ones included; wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt_q <= '0;
    end else if (ctrl.instr_done) begin
      retired_cnt_q <= retired_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle control FSM with a 4-bit retired counter.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
// Expected control words are written out by hand per state.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [3:0] retired_cnt;
  int         vectors;
  int         miscompares;

  multicycle_control_fsm_if bus_if ();

  multicycle_control_fsm #(.CNT_WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: PCWrite CondEQ CondNE IorD MemRead MemWrite IRWrite MemtoReg RegDst
  //              RegWrite ALUSrcA ALUSrcB ZeroExt ALUOp PCSource instr_done illegal_op
  function automatic logic [22:0] cw(
    input logic pcw, ceq, cne, iord, mr, mw, irw,
    input logic [1:0] m2r, rdst,
    input logic rw, srca,
    input logic [1:0] srcb,
    input logic zext,
    input logic [2:0] aluop,
    input logic [1:0] pcsrc,
    input logic done, ill);
    return {pcw, ceq, cne, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, zext,
            aluop, pcsrc, done, ill};
  endfunction

  function automatic logic [22:0] obs();
    return {bus_if.PCWrite, bus_if.PCWriteCondEQ, bus_if.PCWriteCondNE, bus_if.IorD,
            bus_if.MemRead, bus_if.MemWrite, bus_if.IRWrite, bus_if.MemtoReg,
            bus_if.RegDst, bus_if.RegWrite, bus_if.ALUSrcA, bus_if.ALUSrcB,
            bus_if.ZeroExt, bus_if.ALUOp, bus_if.PCSource, bus_if.instr_done,
            bus_if.illegal_op};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] op, input logic rdy,
                      input logic [22:0] expw);
    @(negedge clk);
    bus_if.OP        = op;
    bus_if.mem_ready = rdy;
    #1;
    check(tag, {9'd0, obs()}, {9'd0, expw});
  endtask

  logic [22:0] W_FETCH_RDY, W_FETCH_WAIT, W_DECODE, W_ILLEGAL, W_R_EXEC, W_R_WB;
  logic [22:0] W_MADDR, W_MREAD, W_MEM_WB, W_MWRITE_WAIT, W_BEQ, W_BNE;
  logic [22:0] W_JUMP, W_JAL, W_ORI_EXEC, W_I_WB;

  initial begin
    vectors     = 0;
    miscompares = 0;
    W_FETCH_RDY   = cw(1,0,0,0,1,0,1, 2'b00,2'b00, 0,0, 2'b01, 0, 3'b000, 2'b00, 0,0);
    W_FETCH_WAIT  = cw(0,0,0,0,1,0,0, 2'b00,2'b00, 0,0, 2'b01, 0, 3'b000, 2'b00, 0,0);
    W_DECODE      = cw(0,0,0,0,0,0,0, 2'b00,2'b00, 0,0, 2'b11, 0, 3'b000, 2'b00, 0,0);
    W_ILLEGAL     = cw(0,0,0,0,0,0,0, 2'b00,2'b00, 0,0, 2'b11, 0, 3'b000, 2'b00, 1,1);
    W_R_EXEC      = cw(0,0,0,0,0,0,0, 2'b00,2'b00, 0,1, 2'b00, 0, 3'b111, 2'b00, 0,0);
    W_R_WB        = cw(0,0,0,0,0,0,0, 2'b00,2'b01, 1,0, 2'b00, 0, 3'b000, 2'b00, 1,0);
    W_MADDR       = cw(0,0,0,0,0,0,0, 2'b00,2'b00, 0,1, 2'b10, 0, 3'b000, 2'b00, 0,0);
    W_MREAD       = cw(0,0,0,1,1,0,0, 2'b00,2'b00, 0,0, 2'b00, 0, 3'b000, 2'b00, 0,0);
    W_MEM_WB      = cw(0,0,0,0,0,0,0, 2'b01,2'b00, 1,0, 2'b00, 0, 3'b000, 2'b00, 1,0);
    W_MWRITE_WAIT = cw(0,0,0,1,0,1,0, 2'b00,2'b00, 0,0, 2'b00, 0, 3'b000, 2'b00, 0,0);
    W_BEQ         = cw(0,1,0,0,0,0,0, 2'b00,2'b00, 0,1, 2'b00, 0, 3'b001, 2'b01, 1,0);
    W_BNE         = cw(0,0,1,0,0,0,0, 2'b00,2'b00, 0,1, 2'b00, 0, 3'b001, 2'b01, 1,0);
    W_JUMP        = cw(1,0,0,0,0,0,0, 2'b00,2'b00, 0,0, 2'b00, 0, 3'b000, 2'b10, 1,0);
    W_JAL         = cw(1,0,0,0,0,0,0, 2'b10,2'b10, 1,0, 2'b00, 0, 3'b000, 2'b10, 1,0);
    W_ORI_EXEC    = cw(0,0,0,0,0,0,0, 2'b00,2'b00, 0,1, 2'b10, 1, 3'b101, 2'b00, 0,0);
    W_I_WB        = cw(0,0,0,0,0,0,0, 2'b00,2'b00, 1,0, 2'b00, 0, 3'b000, 2'b00, 1,0);

    // Reset held low for three cycles
    reset            = 1'b1;
    bus_if.OP        = 6'h00;
    bus_if.mem_ready = 1'b1;
    #2 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("reset_ctrl", {9'd0, obs()}, 32'd0);
      check("reset_cnt", {28'd0, retired_cnt}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Zero-wait R-type: 4 cycles
    step("r_fetch",  6'h00, 1'b1, W_FETCH_RDY);
    check("r_cnt_before", {28'd0, retired_cnt}, 32'd0);
    step("r_decode", 6'h00, 1'b1, W_DECODE);
    step("r_exec",   6'h00, 1'b1, W_R_EXEC);
    step("r_wb",     6'h00, 1'b1, W_R_WB);

    // LW with two wait cycles in MEM_READ: 7 cycles
    step("lw_fetch",  6'h23, 1'b1, W_FETCH_RDY);
    check("lw_cnt_before", {28'd0, retired_cnt}, 32'd1);
    step("lw_decode", 6'h23, 1'b1, W_DECODE);
    step("lw_maddr",  6'h23, 1'b1, W_MADDR);
    step("lw_wait1",  6'h23, 1'b0, W_MREAD);
    step("lw_wait2",  6'h23, 1'b0, W_MREAD);
    step("lw_ready",  6'h23, 1'b1, W_MREAD);
    step("lw_wb",     6'h23, 1'b1, W_MEM_WB);

    // One FETCH wait, then BEQ
    step("beq_fwait",  6'h04, 1'b0, W_FETCH_WAIT);
    check("beq_cnt_before", {28'd0, retired_cnt}, 32'd2);
    step("beq_fetch",  6'h04, 1'b1, W_FETCH_RDY);
    step("beq_decode", 6'h04, 1'b1, W_DECODE);
    step("beq_branch", 6'h04, 1'b1, W_BEQ);

    // BNE
    step("bne_fetch",  6'h05, 1'b1, W_FETCH_RDY);
    check("bne_cnt_before", {28'd0, retired_cnt}, 32'd3);
    step("bne_decode", 6'h05, 1'b1, W_DECODE);
    step("bne_branch", 6'h05, 1'b1, W_BNE);

    // JAL
    step("jal_fetch",  6'h03, 1'b1, W_FETCH_RDY);
    check("jal_cnt_before", {28'd0, retired_cnt}, 32'd4);
    step("jal_decode", 6'h03, 1'b1, W_DECODE);
    step("jal_exec",   6'h03, 1'b1, W_JAL);

    // Illegal opcode: pulse in DECODE, straight back to FETCH
    step("ill_fetch",  6'h3f, 1'b1, W_FETCH_RDY);
    check("ill_cnt_before", {28'd0, retired_cnt}, 32'd5);
    step("ill_decode", 6'h3f, 1'b1, W_ILLEGAL);

    // ORI
    step("ori_fetch",  6'h0d, 1'b1, W_FETCH_RDY);
    check("ori_cnt_before", {28'd0, retired_cnt}, 32'd6);
    step("ori_decode", 6'h0d, 1'b1, W_DECODE);
    step("ori_exec",   6'h0d, 1'b1, W_ORI_EXEC);
    step("ori_wb",     6'h0d, 1'b1, W_I_WB);

    // SW interrupted by reset while waiting on memory
    step("sw_fetch",  6'h2b, 1'b1, W_FETCH_RDY);
    check("sw_cnt_before", {28'd0, retired_cnt}, 32'd7);
    step("sw_decode", 6'h2b, 1'b1, W_DECODE);
    step("sw_maddr",  6'h2b, 1'b1, W_MADDR);
    step("sw_wait1",  6'h2b, 1'b0, W_MWRITE_WAIT);
    step("sw_wait2",  6'h2b, 1'b0, W_MWRITE_WAIT);
    #2 reset = 1'b0;
    #1;
    check("sw_reset_ctrl", {9'd0, obs()}, 32'd0);
    check("sw_reset_cnt", {28'd0, retired_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Sixteen jumps wrap the 4-bit counter back to 0
    for (int i = 0; i < 16; i++) begin
      step("jmp_fetch", 6'h02, 1'b1, W_FETCH_RDY);
      check("jmp_cnt", {28'd0, retired_cnt}, i);
      step("jmp_decode", 6'h02, 1'b1, W_DECODE);
      step("jmp_exec",   6'h02, 1'b1, W_JUMP);
    end
    step("wrap_fetch", 6'h00, 1'b1, W_FETCH_RDY);
    check("wrap_cnt", {28'd0, retired_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
